// File: rtl/qerv_bufreg_n.sv
// Buffer register for the qerv serial core: accumulates rs1+imm a chunk at a time,
// holds the result as bus address / rs1 extension, and shifts it back out for shift ops.
module qerv_bufreg_n #(
  parameter int BITS_PER_CYCLE = 4,
  parameter int MDU            = 0,
  parameter int LB             = $clog2(BITS_PER_CYCLE)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_init,
  input  logic                 i_mdu_op,
  input  logic                 i_rs1_en,
  input  logic                 i_imm_en,
  input  logic                 i_clr_lsb,
  input  logic                 i_shift_op,
  input  logic                 i_right_shift_op,
  input  logic                 i_sh_signed,
  input  logic [1:0]           i_size,
  input  logic [BITS_PER_CYCLE-1:0] i_rs1,
  input  logic [BITS_PER_CYCLE-1:0] i_imm,
  input  logic [LB:0]          i_shamt_lsb,
  output logic [BITS_PER_CYCLE-1:0] o_q,
  output logic [((5-LB) < 1 ? 1 : (5-LB))-1:0] o_cnt,
  output logic                 o_last,
  output logic [1:0]           o_lsb,
  output logic                 o_misalign,
  output logic [3:0]           o_dbus_sel,
  output logic [31:0]          o_dbus_adr,
  output logic [31:0]          o_ext_rs1
);

  localparam int W  = BITS_PER_CYCLE;
  localparam int CW = ((5 - LB) < 1) ? 1 : (5 - LB);
  localparam logic [CW-1:0] CNT_MAX = CW'(32 / W - 1);

  generate
    if (!(W == 1 || W == 2 || W == 4 || W == 8)) begin : g_bad_width
      $error("qerv_bufreg_n: BITS_PER_CYCLE must be 1, 2, 4 or 8");
    end
  endgenerate

  logic [31:0]   data_reg;
  logic          c_reg;
  logic [1:0]    lsb_reg;
  logic [CW-1:0] cnt_reg;
  logic [W-1:0]  spill_reg;

  logic          cnt0;
  logic [W-1:0]  rs1_eff;
  logic [W-1:0]  imm_eff;
  logic [W:0]    sum;
  logic [W-1:0]  q_sum;
  logic [W-1:0]  fill;
  logic [LB:0]   sa;
  logic [2*W-1:0] p;
  logic          mdu_gate;

  assign cnt0    = (cnt_reg == '0);
  assign rs1_eff = i_rs1_en ? i_rs1 : '0;
  assign imm_eff = i_imm_en ? ((i_clr_lsb && cnt0) ? (i_imm & ~W'(1)) : i_imm) : '0;
  assign sum     = {1'b0, rs1_eff} + {1'b0, imm_eff} + {{W{1'b0}}, c_reg};
  assign q_sum   = sum[W-1:0];
  assign fill    = {W{i_sh_signed & data_reg[31]}};
  assign o_last  = i_en && (cnt_reg == CNT_MAX);

  // Right shifts are realised as a left shift by the complement within one chunk;
  // shamt==0 yields a full-chunk delay that the core's shift counter accounts for.
  always_comb begin
    sa = '0;
    if (i_shift_op) begin
      if (!i_right_shift_op)
        sa = i_shamt_lsb;
      else if (W > 1)
        sa = (LB+1)'(W) - i_shamt_lsb;
    end
  end

  assign p   = {{W{1'b0}}, data_reg[W-1:0]} << sa;
  assign o_q = i_en ? (p[W-1:0] | (cnt0 ? '0 : spill_reg)) : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_reg  <= '0;
      c_reg     <= 1'b0;
      cnt_reg   <= '0;
      spill_reg <= '0;
    end else if (i_en) begin
      data_reg  <= {(i_init ? q_sum : fill), data_reg[31:W]};
      c_reg     <= sum[W] & ~o_last;
      cnt_reg   <= cnt_reg + CW'(1);
      spill_reg <= p[2*W-1:W];
    end
  end

  generate
    if (W == 1) begin : g_lsb_serial
      // A single-bit datapath sees address bits 0 and 1 on consecutive chunks.
      always_ff @(posedge i_clk) begin
        if (i_rst)
          lsb_reg <= '0;
        else if (i_en && i_init) begin
          if (cnt0)
            lsb_reg[0] <= q_sum[0];
          if (cnt_reg == CW'(1))
            lsb_reg[1] <= q_sum[0];
        end
      end
    end else begin : g_lsb_wide
      always_ff @(posedge i_clk) begin
        if (i_rst)
          lsb_reg <= '0;
        else if (i_en && i_init && cnt0)
          lsb_reg <= q_sum[1:0];
      end
    end
  endgenerate

  assign mdu_gate = (MDU != 0) && i_mdu_op;
  assign o_lsb    = mdu_gate ? 2'b00 : lsb_reg;

  always_comb begin
    o_misalign = 1'b0;
    o_dbus_sel = 4'b1111;
    case (i_size)
      2'b00: o_dbus_sel = 4'b0001 << lsb_reg;
      2'b01: begin
        o_dbus_sel = lsb_reg[1] ? 4'b1100 : 4'b0011;
        o_misalign = lsb_reg[0];
      end
      default: o_misalign = (lsb_reg != 2'b00);
    endcase
    if (mdu_gate)
      o_misalign = 1'b0;
  end

  assign o_cnt      = cnt_reg;
  assign o_dbus_adr = {data_reg[31:2], 2'b00};
  assign o_ext_rs1  = data_reg;

endmodule

// File: tb/tb_qerv_bufreg_n.sv
// Scoreboard bench for qerv_bufreg_n: a W=4 instance and a W=1/MDU=1 instance,
// checked against a word-level model of address generation and shifting.
module tb_qerv_bufreg_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, init, mdu_op, rs1_en, imm_en, clr_lsb, shift_op, right, sh_signed;
  logic [1:0] size;
  logic en4, en1;
  logic [3:0] rs1_4, imm_4;
  logic [2:0] shamt4;
  logic [0:0] rs1_1, imm_1, shamt1;

  logic [3:0]  o_q4, o_sel4, o_q1_sel;
  logic [2:0]  o_cnt4;
  logic        o_last4, o_mis4;
  logic [1:0]  o_lsb4;
  logic [31:0] o_adr4, o_ext4;
  logic [0:0]  o_q1;
  logic [4:0]  o_cnt1;
  logic        o_last1, o_mis1;
  logic [1:0]  o_lsb1;
  logic [31:0] o_adr1, o_ext1;

  qerv_bufreg_n #(.BITS_PER_CYCLE(4), .MDU(0)) u4 (
    .i_clk(clk), .i_rst(rst), .i_en(en4), .i_init(init), .i_mdu_op(mdu_op),
    .i_rs1_en(rs1_en), .i_imm_en(imm_en), .i_clr_lsb(clr_lsb), .i_shift_op(shift_op),
    .i_right_shift_op(right), .i_sh_signed(sh_signed), .i_size(size),
    .i_rs1(rs1_4), .i_imm(imm_4), .i_shamt_lsb(shamt4),
    .o_q(o_q4), .o_cnt(o_cnt4), .o_last(o_last4), .o_lsb(o_lsb4), .o_misalign(o_mis4),
    .o_dbus_sel(o_sel4), .o_dbus_adr(o_adr4), .o_ext_rs1(o_ext4));

  qerv_bufreg_n #(.BITS_PER_CYCLE(1), .MDU(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_en(en1), .i_init(init), .i_mdu_op(mdu_op),
    .i_rs1_en(rs1_en), .i_imm_en(imm_en), .i_clr_lsb(clr_lsb), .i_shift_op(shift_op),
    .i_right_shift_op(right), .i_sh_signed(sh_signed), .i_size(size),
    .i_rs1(rs1_1), .i_imm(imm_1), .i_shamt_lsb(shamt1),
    .o_q(o_q1), .o_cnt(o_cnt1), .o_last(o_last1), .o_lsb(o_lsb1), .o_misalign(o_mis1),
    .o_dbus_sel(o_q1_sel), .o_dbus_adr(o_adr1), .o_ext_rs1(o_ext1));

  typedef struct { logic [3:0] q; logic last; } chunk_t;
  typedef struct { int fld; logic [31:0] exp; } stat_t;
  chunk_t cq4[$];
  chunk_t cq1[$];
  stat_t  sq[$];

  localparam int F_EXT4 = 0, F_ADR4 = 1, F_LSB4 = 2, F_MIS4 = 3, F_SEL4 = 4, F_CNT4 = 5;
  localparam int F_EXT1 = 6, F_LSB1 = 7, F_MIS1 = 8, F_SEL1 = 9, F_CNT1 = 10;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_d4, m_d1;
  logic [1:0]  m_lsb4, m_lsb1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic string fname(input int f);
    case (f)
      F_EXT4: return "ext_rs1_w4";
      F_ADR4: return "dbus_adr_w4";
      F_LSB4: return "lsb_w4";
      F_MIS4: return "misalign_w4";
      F_SEL4: return "dbus_sel_w4";
      F_CNT4: return "cnt_w4";
      F_EXT1: return "ext_rs1_w1";
      F_LSB1: return "lsb_w1";
      F_MIS1: return "misalign_w1";
      F_SEL1: return "dbus_sel_w1";
      default: return "cnt_w1";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int f);
    case (f)
      F_EXT4: return o_ext4;
      F_ADR4: return o_adr4;
      F_LSB4: return {30'b0, o_lsb4};
      F_MIS4: return {31'b0, o_mis4};
      F_SEL4: return {28'b0, o_sel4};
      F_CNT4: return {29'b0, o_cnt4};
      F_EXT1: return o_ext1;
      F_LSB1: return {30'b0, o_lsb1};
      F_MIS1: return {31'b0, o_mis1};
      F_SEL1: return {28'b0, o_q1_sel};
      default: return {27'b0, o_cnt1};
    endcase
  endfunction

  // Byte-lane model: a byte picks its lane, a half picks low or high pair, words take all.
  function automatic logic [31:0] ref_sel(input logic [1:0] sz, input logic [1:0] l);
    case (sz)
      2'd0: return 32'(1 << l);
      2'd1: return (l >= 2) ? 32'hC : 32'h3;
      default: return 32'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_mis(input logic [1:0] sz, input logic [1:0] l);
    case (sz)
      2'd0: return 0;
      2'd1: return {31'b0, l[0]};
      default: return {31'b0, l != 2'b00};
    endcase
  endfunction

  // Monitor: consumes one expected chunk whenever a DUT is enabled, plus any queued status checks.
  always @(negedge clk) begin
    if (!rst) begin
      if (en4) begin
        if (cq4.size() == 0) cmp("chunk_w4_unexpected", 32'd1, 32'd0);
        else begin
          chunk_t c;
          c = cq4.pop_front();
          cmp("q_w4", {28'b0, o_q4}, {28'b0, c.q});
          cmp("last_w4", {31'b0, o_last4}, {31'b0, c.last});
        end
      end else begin
        cmp("q_w4_idle", {28'b0, o_q4}, 32'd0);
        cmp("last_w4_idle", {31'b0, o_last4}, 32'd0);
      end
      if (en1) begin
        if (cq1.size() == 0) cmp("chunk_w1_unexpected", 32'd1, 32'd0);
        else begin
          chunk_t c;
          c = cq1.pop_front();
          cmp("q_w1", {31'b0, o_q1}, {28'b0, c.q});
          cmp("last_w1", {31'b0, o_last1}, {31'b0, c.last});
        end
      end else begin
        cmp("last_w1_idle", {31'b0, o_last1}, 32'd0);
      end
      while (sq.size() != 0) begin
        stat_t s;
        s = sq.pop_front();
        cmp(fname(s.fld), actual(s.fld), s.exp);
      end
    end
  end

  task automatic chk(input int f, input logic [31:0] e);
    sq.push_back('{f, e});
  endtask

  task automatic op4(input bit ini, input logic [31:0] rs1, input logic [31:0] imm,
                     input bit re, input bit ie, input bit clr, input bit sh,
                     input bit rt, input bit sg, input logic [2:0] shamt);
    logic [31:0] strm, nd;
    int sa;
    sa   = !sh ? 0 : (!rt ? int'(shamt) : ((4 - int'(shamt)) & 7));
    strm = m_d4 << sa;
    nd   = ini ? ((re ? rs1 : 32'd0) + (ie ? (clr ? (imm & ~32'd1) : imm) : 32'd0))
               : ((sg && m_d4[31]) ? 32'hFFFF_FFFF : 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      en4 = 1'b1; init = ini; rs1_en = re; imm_en = ie; clr_lsb = clr;
      shift_op = sh; right = rt; sh_signed = sg; shamt4 = shamt;
      rs1_4 = rs1[4*k +: 4]; imm_4 = imm[4*k +: 4];
      cq4.push_back('{strm[4*k +: 4], k == 7});
    end
    @(posedge clk); #1;
    en4 = 1'b0;
    m_d4 = nd;
    if (ini) m_lsb4 = nd[1:0];
  endtask

  task automatic op1(input bit ini, input logic [31:0] rs1, input logic [31:0] imm, input bit sg);
    logic [31:0] nd;
    nd = ini ? (rs1 + imm) : ((sg && m_d1[31]) ? 32'hFFFF_FFFF : 32'd0);
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      en1 = 1'b1; init = ini; rs1_en = 1'b1; imm_en = 1'b1; clr_lsb = 1'b0;
      shift_op = 1'b0; right = 1'b0; sh_signed = sg; shamt1 = 1'b0;
      rs1_1 = rs1[k]; imm_1 = imm[k];
      cq1.push_back('{{3'b0, m_d1[k]}, k == 31});
    end
    @(posedge clk); #1;
    en1 = 1'b0;
    m_d1 = nd;
    if (ini) m_lsb1 = nd[1:0];
  endtask

  task automatic status4(input logic [1:0] sz);
    size = sz;
    mdu_op = 1'($urandom_range(0, 1));
    chk(F_EXT4, m_d4);
    chk(F_ADR4, m_d4 & ~32'd3);
    chk(F_LSB4, {30'b0, m_lsb4});
    chk(F_MIS4, ref_mis(sz, m_lsb4));
    chk(F_SEL4, ref_sel(sz, m_lsb4));
    chk(F_CNT4, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic status1(input logic [1:0] sz, input bit mdu);
    size = sz;
    mdu_op = mdu;
    chk(F_EXT1, m_d1);
    chk(F_LSB1, mdu ? 32'd0 : {30'b0, m_lsb1});
    chk(F_MIS1, mdu ? 32'd0 : ref_mis(sz, m_lsb1));
    chk(F_SEL1, ref_sel(sz, m_lsb1));
    chk(F_CNT1, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en4 = 1'b1; en1 = 1'b1; init = 1'b1; mdu_op = 1'b0;
    rs1_en = 1'b1; imm_en = 1'b1; clr_lsb = 1'b0; shift_op = 1'b0; right = 1'b0;
    sh_signed = 1'b0; size = 2'b00; rs1_4 = 4'hF; imm_4 = 4'h0; shamt4 = '0;
    rs1_1 = 1'b1; imm_1 = 1'b0; shamt1 = '0;
    m_d4 = '0; m_d1 = '0; m_lsb4 = '0; m_lsb1 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; en4 = 1'b0; en1 = 1'b0;
    status4(2'b00);
    status1(2'b00, 1'b0);

    // Address generation and access-size decode
    op4(1, 32'h1000_0003, 32'h0000_0FFE, 1, 1, 0, 0, 0, 0, 0);
    status4(2'b10);
    status4(2'b00);

    // Carry isolation between consecutive operations and clr_lsb
    op4(1, 32'hFFFF_FFFF, 32'h1, 1, 1, 0, 0, 0, 0, 0);
    status4(2'b10);
    op4(1, 32'h10, 32'h05, 1, 1, 1, 0, 0, 0, 0);
    status4(2'b00);

    // Left and right shifts
    op4(1, 32'h1, 32'h0, 1, 1, 0, 0, 0, 0, 0);
    op4(0, 32'h0, 32'h0, 0, 0, 0, 1, 0, 0, 3'd3);
    op4(1, 32'hF, 32'h0, 1, 1, 0, 0, 0, 0, 0);
    op4(0, 32'h0, 32'h0, 0, 0, 0, 1, 0, 0, 3'd3);
    op4(1, 32'hA5C3_1E77, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    op4(0, 32'h0, 32'h0, 0, 0, 0, 1, 1, 0, 3'd0);
    op4(1, 32'h9137_BEEF, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    op4(0, 32'h0, 32'h0, 0, 0, 0, 1, 1, 1, 3'd2);

    // Sign refill
    op4(1, 32'h8000_0000, 32'h0, 1, 1, 0, 0, 0, 0, 0);
    op4(0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1, 3'd0);
    status4(2'b10);

    // Half-word lane selection and misalignment
    op4(1, 32'h0000_0102, 32'h0, 1, 1, 0, 0, 0, 0, 0);
    status4(2'b01);
    op4(1, 32'h0000_0103, 32'h0, 1, 1, 0, 0, 0, 0, 0);
    status4(2'b01);
    status4(2'b11);

    // Reset mid-operation abandons all partial state
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      en4 = 1'b1; init = 1'b1; rs1_en = 1'b1; imm_en = 1'b1; clr_lsb = 1'b0;
      shift_op = 1'b0; sh_signed = 1'b0; rs1_4 = 4'hF; imm_4 = 4'hF;
      cq4.push_back('{m_d4[4*k +: 4], 1'b0});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; en4 = 1'b0;
    m_d4 = '0; m_lsb4 = '0;
    status4(2'b10);
    op4(1, 32'h0000_0011, 32'h0000_0022, 1, 1, 0, 0, 0, 0, 0);
    status4(2'b00);

    // Serial instance: sign refill over 32 chunks, MDU gating of lsb/misalign
    op1(1, 32'h8000_0000, 32'h0, 0);
    op1(0, 32'h0, 32'h0, 1);
    status1(2'b10, 1'b0);
    op1(1, 32'h1234_5670, 32'h3, 0);
    status1(2'b01, 1'b1);
    status1(2'b01, 1'b0);
    status1(2'b00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      op1(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 1)));
      status1(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Randomized operations on the nibble-wide instance
    for (int i = 0; i < 40; i++) begin
      op4(1'($urandom_range(0, 2) != 0), $urandom, $urandom,
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 3)));
      status4(2'($urandom_range(0, 3)));
    end

    repeat (2) @(posedge clk);
    #1;
    if (cq4.size() != 0 || cq1.size() != 0 || sq.size() != 0)
      cmp("scoreboard_leftover", 32'(cq4.size() + cq1.size() + sq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
